perf_csr_sampler: RTL

PERF_CSR_SAMPLER -- requirements
Module: perf_csr_sampler

---
 rtl/perf_csr_sampler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/perf_csr_sampler.sv
// Scans the CSR counters selected by counter_mask (12'hB00+k), periodically or on trigger, into a sample FIFO.
// Build option: define PERF_CSR_SAMPLER_CLEAR_EN to follow each read with a read-and-clear write cycle.
module perf_csr_sampler #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [31:0]           period,
  input  logic [31:0]           counter_mask,
  input  logic                  trigger,
  input  logic                  overrun_clr,
  output logic [11:0]           csr_addr,
  output logic [DATA_WIDTH-1:0] csr_write_data,
  output logic [1:0]            csr_op,
  input  logic [DATA_WIDTH-1:0] csr_read_data,
  input  logic                  csr_valid,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic [4:0]            sample_idx,
  output logic [DATA_WIDTH-1:0] sample_data,
  output logic                  sample_err,
  output logic                  sample_last,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]            idx;
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
    logic                  last;
  } sample_t;

`ifdef PERF_CSR_SAMPLER_CLEAR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, READ = 2'd2, CLEAR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, READ = 2'd2} state_t;
`endif

  state_t            state, state_nxt;
  logic [4:0]        idx, idx_nxt, low_idx;
  logic [31:0]       snap, snap_nxt;
  logic [31:0]       timer;
  logic              run, tick, req, last;
  logic              push, pop, full;
  sample_t           mem [FIFO_DEPTH];
  sample_t           entry, head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  assign run   = enable && (period != 32'd0);
  assign tick  = run && (timer >= period - 32'd1);
  assign req   = tick || trigger;
  assign busy  = (state != IDLE);
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop   = (count != '0) && sample_ready;
  assign last  = ((snap & ~(32'd1 << idx)) == 32'd0);
  assign entry = '{idx: idx, data: csr_read_data, err: ~csr_valid, last: last};
  assign head  = mem[rd_ptr];

  // Lowest set bit of the remaining snapshot mask.
  always_comb begin
    low_idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (snap[i]) low_idx = 5'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 5'd0;
      snap  <= 32'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      snap  <= snap_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    snap_nxt       = snap;
    push           = 1'b0;
    csr_addr       = 12'h000;
    csr_op         = 2'b00;
    csr_write_data = '0;
    case (state)
      IDLE: begin
        if (req && (counter_mask != 32'd0)) begin
          snap_nxt  = counter_mask;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (snap == 32'd0) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt   = low_idx;
          state_nxt = READ;
        end
      end
      READ: begin
        csr_addr = 12'hB00 + 12'(idx);
        // Hold here until the FIFO can take the sample.
        if (!full || pop) begin
          push           = 1'b1;
          snap_nxt[idx]  = 1'b0;
`ifdef PERF_CSR_SAMPLER_CLEAR_EN
          state_nxt      = CLEAR;
`else
          state_nxt      = SCAN;
`endif
        end
      end
`ifdef PERF_CSR_SAMPLER_CLEAR_EN
      CLEAR: begin
        csr_addr  = 12'hB00 + 12'(idx);
        csr_op    = 2'b01;
        state_nxt = SCAN;
      end
`endif
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      push     = 1'b0;
      csr_addr = 12'h000;
      csr_op   = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !run || tick) timer <= 32'd0;
    else                     timer <= timer + 32'd1;
  end

  // Sticky overrun: a dropped request wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst)                 overrun <= 1'b0;
    else if (req && busy)    overrun <= 1'b1;
    else if (overrun_clr)    overrun <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign sample_valid = !rst && (count != '0);
  assign sample_idx   = sample_valid ? head.idx  : 5'd0;
  assign sample_data  = sample_valid ? head.data : '0;
  assign sample_err   = sample_valid && head.err;
  assign sample_last  = sample_valid && head.last;

endmodule
